clk_control_unit: RTL and testbench

Command-driven control stage sitting directly upstream of `ClkDivider`. It accepts 32-bit command words from the controller's host link through a valid/ready interface. It drives the divider's `divider`, `pulse`, `option`, `out_enable` and `write_pulse` inputs, monitors `clk_o` to detect completion of pulse bursts, and returns one 32-bit response word per command.

---
 rtl/clk_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_clk_control_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_control_unit.sv
// Command-driven control stage for ClkDivider: decodes host command words, drives the divider inputs, returns one response per command.
// Optional burst watchdog enabled by defining CLK_CTRL_TIMEOUT_EN.
module clk_control_unit #(
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    input  logic                          clk_o_mon,
    output logic [COUNTER_BITS-1:0]       divider,
    output logic [PULSE_CONTROL_BITS-1:0] pulse,
    output logic                          option,
    output logic                          out_enable,
    output logic                          write_pulse
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARG    = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam logic [7:0] OP_SET_DIV = 8'h01;
    localparam logic [7:0] OP_RUN     = 8'h02;
    localparam logic [7:0] OP_STOP    = 8'h03;
    localparam logic [7:0] OP_PULSE   = 8'h04;
    localparam logic [7:0] OP_STATUS  = 8'h05;

    localparam logic [PULSE_CONTROL_BITS-1:0] COUNT_ONE = 1;

    logic [2:0]                    state;
    logic [7:0]                    op;
    logic [PULSE_CONTROL_BITS-1:0] edge_count;
    logic                          clk_prev;
    logic                          accept;
    logic [7:0]                    cmd_op;
    logic [COUNTER_BITS-1:0]       div_arg;
    logic [PULSE_CONTROL_BITS-1:0] n_arg;
    logic [31:0]                   n_word;
    logic                          edge_seen;
    logic                          last_edge;
    logic                          wd_expired;

    function automatic logic [31:0] ack_word(input logic [7:0] code);
        return {8'hAC, 16'h0000, code};
    endfunction

    function automatic logic [31:0] err_word(input logic [7:0] code);
        return {16'hEEEE, 8'h00, code};
    endfunction

    // Width adaptation between the 32-bit host words and the divider register widths.
    generate
        if (COUNTER_BITS <= 32) begin : g_div_trunc
            assign div_arg = cmd_data[COUNTER_BITS-1:0];
        end else begin : g_div_ext
            assign div_arg = {{(COUNTER_BITS-32){1'b0}}, cmd_data};
        end
        if (PULSE_CONTROL_BITS <= 32) begin : g_n_trunc
            assign n_arg = cmd_data[PULSE_CONTROL_BITS-1:0];
        end else begin : g_n_ext
            assign n_arg = {{(PULSE_CONTROL_BITS-32){1'b0}}, cmd_data};
        end
        if (PULSE_CONTROL_BITS < 32) begin : g_w_ext
            assign n_word = {{(32-PULSE_CONTROL_BITS){1'b0}}, pulse};
        end else begin : g_w_trunc
            assign n_word = pulse[31:0];
        end
    endgenerate

    // Handshake: a word transfers on an edge where cmd_valid && cmd_ready; a
    // response transfers on an edge where rsp_valid && rsp_ready. Both ready and
    // valid are pure decodes of the state register.
    assign cmd_ready   = (state == IDLE) || (state == ARG);
    assign rsp_valid   = (state == RESP);
    assign write_pulse = (state == STROBE);
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_op      = cmd_data[7:0];
    assign edge_seen   = clk_o_mon && !clk_prev;
    assign last_edge   = edge_seen && ((edge_count + COUNT_ONE) == pulse);

`ifdef CLK_CTRL_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);
    logic [WD_BITS-1:0] wd_count;

    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wd_count <= '0;
        end else if (!wd_expired) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    assign wd_expired = (state == WAIT) && (wd_count == WD_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= 8'h00;
            edge_count <= '0;
            clk_prev   <= 1'b0;
            rsp_data   <= 32'h0;
            divider    <= '0;
            pulse      <= '0;
            option     <= 1'b1;
            out_enable <= 1'b1;
        end else begin
            clk_prev <= clk_o_mon;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op <= cmd_op;
                        case (cmd_op)
                            OP_SET_DIV, OP_PULSE: state <= ARG;
                            OP_RUN: begin
                                option     <= 1'b1;
                                out_enable <= 1'b1;
                                rsp_data   <= ack_word(cmd_op);
                                state      <= RESP;
                            end
                            OP_STOP: begin
                                out_enable <= 1'b0;
                                rsp_data   <= ack_word(cmd_op);
                                state      <= RESP;
                            end
                            OP_STATUS: begin
                                rsp_data <= {16'h0000, 8'h05, 6'b0, option, out_enable};
                                state    <= RESP;
                            end
                            default: begin
                                rsp_data <= err_word(cmd_op);
                                state    <= RESP;
                            end
                        endcase
                    end
                end
                ARG: begin
                    if (accept) begin
                        if (op == OP_SET_DIV) begin
                            divider  <= div_arg;
                            rsp_data <= ack_word(op);
                            state    <= RESP;
                        end else if (n_arg == '0) begin
                            rsp_data <= 32'h0;
                            state    <= RESP;
                        end else begin
                            pulse      <= n_arg;
                            option     <= 1'b0;
                            out_enable <= 1'b1;
                            state      <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    edge_count <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A completing edge takes priority over a simultaneous watchdog expiry.
                    if (last_edge) begin
                        rsp_data <= n_word;
                        state    <= RESP;
                    end else if (wd_expired) begin
                        out_enable <= 1'b0;
                        rsp_data   <= err_word(OP_PULSE);
                        state      <= RESP;
                    end else if (edge_seen) begin
                        edge_count <= edge_count + COUNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_control_unit.sv
// Directed bench for clk_control_unit; clk_o_mon edges are driven by hand to stand in for ClkDivider.
module tb_clk_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        clk_o_mon = 1'b0;
    logic [31:0] divider;
    logic [31:0] pulse;
    logic        option;
    logic        out_enable;
    logic        write_pulse;

    int tests = 0;
    int fails = 0;

    clk_control_unit #(
        .COUNTER_BITS(32),
        .PULSE_CONTROL_BITS(32),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .clk_o_mon(clk_o_mon),
        .divider(divider),
        .pulse(pulse),
        .option(option),
        .out_enable(out_enable),
        .write_pulse(write_pulse)
    );

    always #5 clk = ~clk;

    // Presents one word for a single cycle; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = w;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({cmd_ready, rsp_valid, option, out_enable, write_pulse} !== 5'b10110) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 10110", {cmd_ready, rsp_valid, option, out_enable, write_pulse});
        end
        tests++;
        if ({rsp_data, divider, pulse} !== 96'h0) begin
            fails++;
            $display("FAIL reset_regs: got %h expected 0", {rsp_data, divider, pulse});
        end
    endtask

    task automatic test_status();
        send_word(32'h0000_0005);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0503 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL status_rsp: got v=%b d=%h r=%b expected v=1 d=00000503 r=0", rsp_valid, rsp_data, cmd_ready);
        end
        tests++;
        if (divider !== 32'h0) begin
            fails++;
            $display("FAIL status_divider: got %h expected 0", divider);
        end
        take_rsp();
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL status_release: got v=%b r=%b expected v=0 r=1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_stop_run();
        send_word(32'hFFFF_FF03);
        tests++;
        if (out_enable !== 1'b0 || rsp_data !== 32'hAC00_0003 || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL stop: got oe=%b d=%h v=%b expected oe=0 d=ac000003 v=1", out_enable, rsp_data, rsp_valid);
        end
        take_rsp();
        send_word(32'h0000_0002);
        tests++;
        if (out_enable !== 1'b1 || option !== 1'b1 || rsp_data !== 32'hAC00_0002) begin
            fails++;
            $display("FAIL run: got oe=%b opt=%b d=%h expected oe=1 opt=1 d=ac000002", out_enable, option, rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_set_div();
        send_word(32'h0000_0001);
        tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL set_div_arg_wait: got r=%b v=%b expected r=1 v=0", cmd_ready, rsp_valid);
        end
        send_word(32'd4);
        tests++;
        if (divider !== 32'd4 || rsp_data !== 32'hAC00_0001 || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL set_div: got div=%h d=%h v=%b expected div=4 d=ac000001 v=1", divider, rsp_data, rsp_valid);
        end
        take_rsp();
    endtask

    task automatic test_pulse();
        logic early;
        logic stable;
        early = 1'b0;
        stable = 1'b1;
        send_word(32'h0000_0004);
        send_word(32'd8);
        tests++;
        if (pulse !== 32'd8 || option !== 1'b0 || out_enable !== 1'b1 || write_pulse !== 1'b1) begin
            fails++;
            $display("FAIL pulse_load: got p=%h opt=%b oe=%b wp=%b expected p=8 opt=0 oe=1 wp=1", pulse, option, out_enable, write_pulse);
        end
        @(negedge clk);
        tests++;
        if (write_pulse !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL pulse_strobe_width: got wp=%b r=%b expected wp=0 r=0", write_pulse, cmd_ready);
        end
        for (int i = 0; i < 8; i++) begin
            clk_o_mon = 1'b1;
            @(negedge clk);
            clk_o_mon = 1'b0;
            if (i < 7 && (rsp_valid || write_pulse)) early = 1'b1;
            if (i < 7) @(negedge clk);
        end
        tests++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL pulse_early: got early=%b expected 0", early);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd8) begin
            fails++;
            $display("FAIL pulse_done: got v=%b d=%h expected v=1 d=8", rsp_valid, rsp_data);
        end
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || pulse !== 32'd8 || option !== 1'b0) stable = 1'b0;
        end
        tests++;
        if (stable !== 1'b1) begin
            fails++;
            $display("FAIL pulse_hold: got stable=%b expected 1", stable);
        end
        take_rsp();
    endtask

    task automatic test_bad_opcode();
        send_word(32'h1234_567F);
        tests++;
        if (rsp_data !== 32'hEEEE_007F || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL bad_op_rsp: got d=%h v=%b expected d=eeee007f v=1", rsp_data, rsp_valid);
        end
        tests++;
        if (divider !== 32'd4 || pulse !== 32'd8 || option !== 1'b0 || out_enable !== 1'b1) begin
            fails++;
            $display("FAIL bad_op_regs: got div=%h p=%h opt=%b oe=%b expected 4 8 0 1", divider, pulse, option, out_enable);
        end
        take_rsp();
    endtask

    task automatic test_pulse_zero();
        logic strobed;
        send_word(32'h0000_0004);
        send_word(32'd0);
        strobed = write_pulse;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
            fails++;
            $display("FAIL pulse_zero_rsp: got v=%b d=%h expected v=1 d=0", rsp_valid, rsp_data);
        end
        @(negedge clk);
        strobed = strobed | write_pulse;
        take_rsp();
        strobed = strobed | write_pulse;
        tests++;
        if (strobed !== 1'b0) begin
            fails++;
            $display("FAIL pulse_zero_strobe: got %b expected 0", strobed);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic moved;
        moved = 1'b0;
        clk_o_mon = 1'b0;
        send_word(32'h0000_0004);
        send_word(32'd8);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_0005;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) moved = 1'b1;
        end
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        tests++;
        if (moved !== 1'b0) begin
            fails++;
            $display("FAIL wait_blocks_cmd: got moved=%b expected 0", moved);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({cmd_ready, rsp_valid, option, out_enable, write_pulse} !== 5'b10110 ||
            {rsp_data, divider, pulse} !== 96'h0) begin
            fails++;
            $display("FAIL reset_mid_wait: got flags=%b regs=%h expected flags=10110 regs=0",
                     {cmd_ready, rsp_valid, option, out_enable, write_pulse}, {rsp_data, divider, pulse});
        end
    endtask

`ifdef CLK_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        waited = 0;
        clk_o_mon = 1'b0;
        send_word(32'h0000_0004);
        send_word(32'd8);
        while (rsp_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hEEEE_0004 || out_enable !== 1'b0) begin
            fails++;
            $display("FAIL timeout: got v=%b d=%h oe=%b expected v=1 d=eeee0004 oe=0", rsp_valid, rsp_data, out_enable);
        end
        tests++;
        if (waited < 30 || waited > 36) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles expected about 33", waited);
        end
        take_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_status();
        test_stop_run();
        test_set_div();
        test_pulse();
        test_bad_opcode();
        test_pulse_zero();
        test_reset_mid_wait();
`ifdef CLK_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
